// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter: LS has fixed priority over IF, with a starvation bound for IF.
// Optional address checking is enabled by defining MEM_ARB_ADDR_CHECK_EN.
module mem_port_arbiter #(
  parameter int unsigned       AWIDTH       = 32,
  parameter int unsigned       DWIDTH       = 32,
  parameter logic [AWIDTH-1:0] BASE_ADDR    = 32'h01000000,
  parameter logic [AWIDTH-1:0] MEM_BYTES    = 32'h00100000,
  parameter int unsigned       STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req_i,
  input  logic [AWIDTH-1:0] if_addr_i,
  output logic              if_gnt_o,
  output logic              if_rvalid_o,
  output logic [DWIDTH-1:0] if_rdata_o,
  output logic              if_err_o,
  input  logic              ls_req_i,
  input  logic              ls_we_i,
  input  logic [AWIDTH-1:0] ls_addr_i,
  input  logic [DWIDTH-1:0] ls_wdata_i,
  output logic              ls_gnt_o,
  output logic              ls_rvalid_o,
  output logic [DWIDTH-1:0] ls_rdata_o,
  output logic              ls_err_o,
  output logic [AWIDTH-1:0] mem_addr_o,
  output logic [DWIDTH-1:0] mem_data_o,
  output logic              mem_read_en_o,
  output logic              mem_write_en_o,
  input  logic [DWIDTH-1:0] mem_data_i
);

  localparam int unsigned   CW    = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

`ifdef MEM_ARB_ADDR_CHECK_EN
  function automatic logic addr_bad(input logic [AWIDTH-1:0] a);
    addr_bad = (a[1:0] != 2'b00) || (a < BASE_ADDR) ||
               (a > BASE_ADDR + MEM_BYTES - AWIDTH'(4));
  endfunction
`endif

  logic [CW-1:0]     r_starve_cnt;
  logic              r_rsp_vld_p1;
  logic              r_rsp_ls_p1;
  logic              r_rsp_err_p1;
  logic [DWIDTH-1:0] r_rsp_data_p1;

  logic              w_starved;
  logic              w_if_gnt;
  logic              w_ls_gnt;
  logic              w_any_gnt;
  logic              w_rd;
  logic              w_err;
  logic [AWIDTH-1:0] w_addr;

  // Stage p0: combinational grant and memory drive
  assign w_starved = if_req_i && (r_starve_cnt == LIMIT);
  assign w_ls_gnt  = !rst && ls_req_i && !w_starved;
  assign w_if_gnt  = !rst && if_req_i && !w_ls_gnt;
  assign w_any_gnt = w_ls_gnt || w_if_gnt;
  assign w_addr    = w_ls_gnt ? ls_addr_i : if_addr_i;
  assign w_rd      = w_if_gnt || (w_ls_gnt && !ls_we_i);

`ifdef MEM_ARB_ADDR_CHECK_EN
  assign w_err = w_any_gnt && addr_bad(w_addr);
`else
  assign w_err = 1'b0;
`endif

  assign if_gnt_o       = w_if_gnt;
  assign ls_gnt_o       = w_ls_gnt;
  assign mem_addr_o     = w_any_gnt ? w_addr : '0;
  assign mem_data_o     = w_any_gnt ? ls_wdata_i : '0;
  assign mem_read_en_o  = w_rd && !w_err;
  assign mem_write_en_o = w_ls_gnt && ls_we_i && !w_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_starve_cnt <= '0;
    end else if (!if_req_i || w_if_gnt) begin
      r_starve_cnt <= '0;
    end else if (r_starve_cnt != LIMIT) begin
      r_starve_cnt <= r_starve_cnt + CW'(1);
    end
  end

  // Stage p1: registered response, routed to the owning port
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rsp_vld_p1 <= 1'b0;
      r_rsp_ls_p1  <= 1'b0;
      r_rsp_err_p1 <= 1'b0;
    end else begin
      r_rsp_vld_p1 <= w_any_gnt;
      r_rsp_ls_p1  <= w_ls_gnt;
      r_rsp_err_p1 <= w_err;
    end
  end

  always_ff @(posedge clk) begin
    r_rsp_data_p1 <= (w_rd && !w_err) ? mem_data_i : '0;
  end

  // Gating with rst drops a response that was pending when reset arrived.
  assign if_rvalid_o = !rst && r_rsp_vld_p1 && !r_rsp_ls_p1;
  assign ls_rvalid_o = !rst && r_rsp_vld_p1 && r_rsp_ls_p1;
  assign if_rdata_o  = if_rvalid_o ? r_rsp_data_p1 : '0;
  assign ls_rdata_o  = ls_rvalid_o ? r_rsp_data_p1 : '0;
  assign if_err_o    = if_rvalid_o && r_rsp_err_p1;
  assign ls_err_o    = ls_rvalid_o && r_rsp_err_p1;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter with a behavioural memory and reference model.
module tb_mem_port_arbiter;

  localparam logic [31:0] BASE  = 32'h01000000;
  localparam logic [31:0] BYTES = 32'h00100000;
  localparam int          LIMIT = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req_i, ls_req_i, ls_we_i;
  logic [31:0] if_addr_i, ls_addr_i, ls_wdata_i;
  logic        if_gnt_o, if_rvalid_o, if_err_o;
  logic        ls_gnt_o, ls_rvalid_o, ls_err_o;
  logic [31:0] if_rdata_o, ls_rdata_o;
  logic [31:0] mem_addr_o, mem_data_o, mem_data_i;
  logic        mem_read_en_o, mem_write_en_o;

  mem_port_arbiter #(
    .AWIDTH(32), .DWIDTH(32), .BASE_ADDR(BASE), .MEM_BYTES(BYTES), .STARVE_LIMIT(LIMIT)
  ) dut (
    .clk(clk), .rst(rst),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_gnt_o(if_gnt_o),
    .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o), .if_err_o(if_err_o),
    .ls_req_i(ls_req_i), .ls_we_i(ls_we_i), .ls_addr_i(ls_addr_i), .ls_wdata_i(ls_wdata_i),
    .ls_gnt_o(ls_gnt_o), .ls_rvalid_o(ls_rvalid_o), .ls_rdata_o(ls_rdata_o), .ls_err_o(ls_err_o),
    .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o),
    .mem_read_en_o(mem_read_en_o), .mem_write_en_o(mem_write_en_o), .mem_data_i(mem_data_i)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        ls;
    logic        err;
    logic [31:0] data;
  } rsp_t;

  rsp_t        exp_q[$];
  logic [31:0] tb_mem [256];
  logic [31:0] ref_mem[256];
  int          m_starve;
  int          n_cmp;
  int          n_bad;

  function automatic int idx(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE;
    return int'(off[9:2]);
  endfunction

  function automatic logic exp_err(input logic [31:0] a);
`ifdef MEM_ARB_ADDR_CHECK_EN
    return (a[1:0] != 2'b00) || (a < BASE) || (a > BASE + BYTES - 32'd4);
`else
    return 1'b0;
`endif
  endfunction

  assign mem_data_i = tb_mem[idx(mem_addr_o)];

  always @(posedge clk) begin
    if (mem_write_en_o) tb_mem[idx(mem_addr_o)] <= mem_data_o;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One clock cycle: drive, check outputs against the model mid-cycle, advance the model.
  task automatic cycle(input logic r, input logic iq, input logic [31:0] ia,
                       input logic lq, input logic lw, input logic [31:0] la,
                       input logic [31:0] ld, output logic gi, output logic gl);
    rsp_t        e;
    logic        ei, el, er, any;
    logic [31:0] wa;
    rst = r; if_req_i = iq; if_addr_i = ia;
    ls_req_i = lq; ls_we_i = lw; ls_addr_i = la; ls_wdata_i = ld;
    #4;
    if (r) exp_q.delete();
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("if_rvalid", {31'd0, if_rvalid_o}, {31'd0, !e.ls});
      check("ls_rvalid", {31'd0, ls_rvalid_o}, {31'd0, e.ls});
      check("if_rdata", if_rdata_o, e.ls ? 32'd0 : e.data);
      check("ls_rdata", ls_rdata_o, e.ls ? e.data : 32'd0);
      check("if_err", {31'd0, if_err_o}, {31'd0, !e.ls && e.err});
      check("ls_err", {31'd0, ls_err_o}, {31'd0, e.ls && e.err});
    end else begin
      check("rvalid_idle", {30'd0, if_rvalid_o, ls_rvalid_o}, 32'd0);
      check("rdata_idle", if_rdata_o | ls_rdata_o, 32'd0);
      check("err_idle", {30'd0, if_err_o, ls_err_o}, 32'd0);
    end
    el  = !r && lq && !(iq && m_starve == LIMIT);
    ei  = !r && iq && !el;
    any = ei || el;
    wa  = el ? la : ia;
    er  = any && exp_err(wa);
    check("if_gnt", {31'd0, if_gnt_o}, {31'd0, ei});
    check("ls_gnt", {31'd0, ls_gnt_o}, {31'd0, el});
    check("mem_addr", mem_addr_o, any ? wa : 32'd0);
    check("mem_data", mem_data_o, any ? ld : 32'd0);
    check("mem_rd_en", {31'd0, mem_read_en_o}, {31'd0, (ei || (el && !lw)) && !er});
    check("mem_wr_en", {31'd0, mem_write_en_o}, {31'd0, el && lw && !er});
    if (any) begin
      e.ls   = el;
      e.err  = er;
      e.data = ((ei || !lw) && !er) ? ref_mem[idx(wa)] : 32'd0;
      exp_q.push_back(e);
    end
    if (r || !iq || ei) m_starve = 0;
    else if (m_starve < LIMIT) m_starve++;
    if (el && lw && !er) ref_mem[idx(la)] = ld;
    gi = ei;
    gl = el;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic        gi, gl;
    logic        ip, lp, lwp;
    logic [31:0] ipa, lpa, lpd, held;
    n_cmp = 0; n_bad = 0; m_starve = 0;
    for (int i = 0; i < 256; i++) begin
      tb_mem[i]  = 32'hA5000000 ^ (i * 32'h00010203);
      ref_mem[i] = 32'hA5000000 ^ (i * 32'h00010203);
    end
    tb_mem[0]  = 32'h00500093;
    ref_mem[0] = 32'h00500093;
    rst = 1'b1; if_req_i = 0; ls_req_i = 0; ls_we_i = 0;
    if_addr_i = 0; ls_addr_i = 0; ls_wdata_i = 0;
    @(posedge clk); #1;

    // reset with both requesting: grants must stay low, no write
    cycle(1, 1, BASE, 1, 1, BASE + 32'h40, 32'h11111111, gi, gl);
    cycle(1, 1, BASE, 1, 1, BASE + 32'h40, 32'h11111111, gi, gl);
    cycle(0, 0, 0, 0, 0, 0, 0, gi, gl);

    // IF-only read of the first word
    cycle(0, 1, BASE, 0, 0, 0, 0, gi, gl);
    check("if_lone_gnt", {31'd0, gi}, 32'd1);
    cycle(0, 0, 0, 0, 0, 0, 0, gi, gl);

    // write then read-back of the same word
    cycle(0, 0, 0, 1, 1, BASE + 32'h10, 32'hDEADBEEF, gi, gl);
    cycle(0, 0, 0, 1, 0, BASE + 32'h10, 0, gi, gl);
    cycle(0, 0, 0, 0, 0, 0, 0, gi, gl);
    check("wr_mem", tb_mem[4], 32'hDEADBEEF);

    // both requesting continuously: IF wins every fifth cycle
    for (int k = 0; k < 10; k++) begin
      cycle(0, 1, BASE + 32'h8, 1, 0, BASE + 32'h20, 0, gi, gl);
      check("starve_pat", {31'd0, gi}, {31'd0, (k == 4) || (k == 9)});
      check("one_gnt", {31'd0, gi && gl}, 32'd0);
    end
    cycle(0, 0, 0, 0, 0, 0, 0, gi, gl);

    // reset right after an LS read grant, with a write presented during reset
    held = tb_mem[idx(BASE + 32'h30)];
    cycle(0, 0, 0, 1, 0, BASE + 32'h30, 0, gi, gl);
    cycle(1, 0, 0, 1, 1, BASE + 32'h30, 32'h12345678, gi, gl);
    cycle(0, 0, 0, 0, 0, 0, 0, gi, gl);
    check("rst_nowrite", tb_mem[idx(BASE + 32'h30)], held);

    // misaligned LS read and out-of-window IF read
    cycle(0, 0, 0, 1, 0, BASE + 32'h2, 0, gi, gl);
    check("bad_ls_gnt", {31'd0, gl}, 32'd1);
    cycle(0, 1, 32'h00FFFFFC, 0, 0, 0, 0, gi, gl);
    check("bad_if_gnt", {31'd0, gi}, 32'd1);
    cycle(0, 1, BASE + BYTES - 32'd4, 0, 0, 0, 0, gi, gl);
    cycle(0, 0, 0, 0, 0, 0, 0, gi, gl);

    // random traffic; requesters hold until granted
    ip = 0; lp = 0; lwp = 0; ipa = 0; lpa = 0; lpd = 0;
    for (int t = 0; t < 300; t++) begin
      if (!ip && $urandom_range(0, 2) != 0) begin
        ip  = 1;
        ipa = BASE + ($urandom_range(0, 63) << 2);
        if ($urandom_range(0, 15) == 0) ipa = ipa + 32'd1;
      end
      if (!lp && $urandom_range(0, 1) != 0) begin
        lp  = 1;
        lwp = $urandom_range(0, 1) != 0;
        lpa = BASE + ($urandom_range(0, 63) << 2);
        lpd = $urandom;
        if ($urandom_range(0, 15) == 0) lpa = BASE + BYTES;
      end
      cycle((t == 150), ip, ipa, lp, lwp, lpa, lpd, gi, gl);
      check("rnd_one_gnt", {31'd0, gi && gl}, 32'd0);
      if (gi) ip = 0;
      if (gl) lp = 0;
    end
    cycle(0, 0, 0, 0, 0, 0, 0, gi, gl);
    cycle(0, 0, 0, 0, 0, 0, 0, gi, gl);

    for (int i = 0; i < 256; i++) check("mem_final", tb_mem[i], ref_mem[i]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
